// File: rtl/control_command_sequencer_if.sv
// Link and control-register port bundle for control_command_sequencer.
// master: host link side (drives received bytes, transmitter ready).
// slave:  the sequencer (drives the response byte and control-register write).
interface control_command_sequencer_if;
    // Receiver side: one-cycle byte pulses
    logic       rx_valid;
    logic [7:0] rx_data;

    // Transmitter side: response byte handshake
    logic       tx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;

    // Control register write port and status
    logic       write;
    logic [7:0] write_register;
    logic       busy;

    modport master (
        output rx_valid,
        output rx_data,
        output tx_ready,
        input  tx_valid,
        input  tx_data,
        input  write,
        input  write_register,
        input  busy
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  tx_ready,
        output tx_valid,
        output tx_data,
        output write,
        output write_register,
        output busy
    );
endinterface

// File: rtl/control_command_sequencer.sv
// control_command_sequencer
// Turns framed host bytes (SYNC, ADDR, DATA) into a single-cycle write of the
// 8-bit control register and answers each complete frame with one response
// byte (ACK, NACK, or readback data).
//
// Optional feature, macro CONTROL_READBACK_EN:
//   defined   - ADDR 8'h80 is a read command; response is the current
//               write_register value, no write is issued.
//   undefined - ADDR 8'h80 is just another invalid address (NACK).
//
// All outputs come straight from flops. Frames that time out or are cut by
// reset vanish without a response.
module control_command_sequencer #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter logic [7:0]  ACK_BYTE       = 8'h06,
    parameter logic [7:0]  NACK_BYTE      = 8'h15,
    // Maximum clk cycles allowed between bytes of one frame, must be >= 2
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic                              clk,
    input  logic                              reset,
    control_command_sequencer_if.slave        bus_io
);

    localparam int unsigned     CntW     = $clog2(TIMEOUT_CYCLES);
    localparam logic [CntW-1:0] CntMax   = CntW'(TIMEOUT_CYCLES - 1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [7:0]      CtrlAddr = 8'h00;
`ifdef CONTROL_READBACK_EN
    localparam logic [7:0]      ReadAddr = 8'h80;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StData,
        StWrite,
        StResp
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [7:0]      addr_q, addr_d;
    logic [7:0]      data_q, data_d;
    logic            tx_valid_q, tx_valid_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            write_q, write_d;
    logic [7:0]      write_reg_q, write_reg_d;
    logic            busy_q, busy_d;

    // Next-state and next-output decode; outputs are computed one edge ahead so
    // they line up with the state they belong to.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        data_d      = data_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        write_d     = 1'b0;
        write_reg_d = write_reg_q;

        unique case (state_q)
            StIdle: begin
                // Anything other than the sync byte is line noise
                if (bus_io.rx_valid && (bus_io.rx_data == SYNC_BYTE)) begin
                    state_d = StAddr;
                    cnt_d   = '0;
                end
            end

            StAddr: begin
                // A byte arriving on the timeout cycle still wins
                if (bus_io.rx_valid) begin
                    addr_d  = bus_io.rx_data;
                    cnt_d   = '0;
                    state_d = StData;
                end else if (cnt_q == CntMax) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StData: begin
                if (bus_io.rx_valid) begin
                    data_d = bus_io.rx_data;
                    cnt_d  = '0;
                    if (addr_q == CtrlAddr) begin
                        state_d     = StWrite;
                        write_d     = 1'b1;
                        write_reg_d = bus_io.rx_data;
`ifdef CONTROL_READBACK_EN
                    end else if (addr_q == ReadAddr) begin
                        // Read command: DATA byte is a don't-care
                        state_d    = StResp;
                        tx_valid_d = 1'b1;
                        tx_data_d  = write_reg_q;
`endif
                    end else begin
                        state_d    = StResp;
                        tx_valid_d = 1'b1;
                        tx_data_d  = NACK_BYTE;
                    end
                end else if (cnt_q == CntMax) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntOne;
                end
            end

            StWrite: begin
                // Strobe lasts exactly this one cycle; the ACK follows
                state_d    = StResp;
                tx_valid_d = 1'b1;
                tx_data_d  = ACK_BYTE;
            end

            StResp: begin
                // No timeout here: the transmitter may stall indefinitely
                if (bus_io.tx_ready) begin
                    state_d    = StIdle;
                    tx_valid_d = 1'b0;
                    tx_data_d  = '0;
                end
            end

            default: begin
                state_d    = StIdle;
                cnt_d      = '0;
                tx_valid_d = 1'b0;
                tx_data_d  = '0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    // Single state/output register bank with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            write_q     <= 1'b0;
            write_reg_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            write_q     <= write_d;
            write_reg_q <= write_reg_d;
            busy_q      <= busy_d;
        end
    end

    assign bus_io.tx_valid       = tx_valid_q;
    assign bus_io.tx_data        = tx_data_q;
    assign bus_io.write          = write_q;
    assign bus_io.write_register = write_reg_q;
    assign bus_io.busy           = busy_q;

endmodule

// File: tb/tb_control_command_sequencer.sv
// Bench for control_command_sequencer: a per-cycle vector table for the basic
// write and NACK frames, hand-written sequences for timeout, backpressure,
// reset and readback, then random traffic against a frame-level model.
module tb_control_command_sequencer;

    localparam int unsigned TO   = 16;
    localparam logic [7:0]  SYNC = 8'hA5;
    localparam logic [7:0]  ACK  = 8'h06;
    localparam logic [7:0]  NACK = 8'h15;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    control_command_sequencer_if bus ();

    control_command_sequencer #(
        .SYNC_BYTE      (SYNC),
        .ACK_BYTE       (ACK),
        .NACK_BYTE      (NACK),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .bus_io (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rv;
        logic [7:0] rd;
        logic       tr;
        logic       e_write;
        logic [7:0] e_wreg;
        logic       e_txv;
        logic [7:0] e_txd;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the edge
    task automatic drive(input logic rv, input logic [7:0] rd, input logic tr);
        bus.rx_valid = rv;
        bus.rx_data  = rd;
        bus.tx_ready = tr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic ew, input logic [7:0] ewr,
                              input logic etv, input logic [7:0] etd, input logic eb);
        chk({tag, ".write"}, 32'(bus.write), 32'(ew));
        chk({tag, ".write_register"}, 32'(bus.write_register), 32'(ewr));
        chk({tag, ".tx_valid"}, 32'(bus.tx_valid), 32'(etv));
        if (etv) chk({tag, ".tx_data"}, 32'(bus.tx_data), 32'(etd));
        chk({tag, ".busy"}, 32'(bus.busy), 32'(eb));
    endtask

    // Frame-level reference model: collected frame bytes, idle gap length,
    // and whether a write strobe or a response is outstanding.
    logic [7:0] m_frame[$];
    int         m_idle;
    bit         m_wpend;
    bit         m_rpend;
    logic [7:0] m_resp;
    logic [7:0] m_wreg;

    task automatic model_reset();
        m_frame.delete();
        m_idle  = 0;
        m_wpend = 0;
        m_rpend = 0;
        m_resp  = '0;
        m_wreg  = '0;
    endtask

    task automatic model_step(input logic rv, input logic [7:0] rd, input logic tr);
        if (m_rpend) begin
            if (tr) m_rpend = 0;
        end else if (m_wpend) begin
            m_wpend = 0;
            m_rpend = 1;
            m_resp  = ACK;
        end else if (m_frame.size() == 0) begin
            if (rv && rd == SYNC) begin
                m_frame.push_back(rd);
                m_idle = 0;
            end
        end else if (rv) begin
            m_frame.push_back(rd);
            m_idle = 0;
            if (m_frame.size() == 3) begin
                if (m_frame[1] == 8'h00) begin
                    m_wreg  = m_frame[2];
                    m_wpend = 1;
`ifdef CONTROL_READBACK_EN
                end else if (m_frame[1] == 8'h80) begin
                    m_resp  = m_wreg;
                    m_rpend = 1;
`endif
                end else begin
                    m_resp  = NACK;
                    m_rpend = 1;
                end
                m_frame.delete();
            end
        end else if (m_idle == int'(TO) - 1) begin
            m_frame.delete();
            m_idle = 0;
        end else begin
            m_idle++;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] junk[3];
        logic [7:0] exp_rb;
        logic       rv;
        logic [7:0] rd;
        logic       tr;
        int         gap;
        int         sel;

        junk[0] = 8'hA5;
        junk[1] = 8'h00;
        junk[2] = 8'h99;

        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        bus.tx_ready = 1'b0;
        reset        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_outs("reset", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // Tests 1 and 2: write frame then bad-address frame, one row per cycle
        //                 rv    rd     tr    wr    wreg   txv   txd    busy
        vecs.push_back('{1'b1, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b1, ACK,   1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 8'h42, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h00, 1'b0});
        vecs.push_back('{1'b1, 8'hA5, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 8'h07, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h00, 1'b1});
        vecs.push_back('{1'b1, 8'hFF, 1'b1, 1'b0, 8'h3C, 1'b1, NACK,  1'b1});
        vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 8'h3C, 1'b0, 8'h00, 1'b0});
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rv, vecs[i].rd, vecs[i].tr);
            check_outs($sformatf("vec%0d", i), vecs[i].e_write, vecs[i].e_wreg,
                       vecs[i].e_txv, vecs[i].e_txd, vecs[i].e_busy);
        end

        // Test 3: silent timeout after 16 idle cycles in DATA
        drive(1'b1, 8'hA5, 1'b1);
        drive(1'b1, 8'h00, 1'b1);
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            check_outs("to_wait", 1'b0, 8'h3C, 1'b0, 8'h00, 1'b1);
        end
        drive(1'b0, 8'h00, 1'b1);
        check_outs("to_expire", 1'b0, 8'h3C, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'h55, 1'b1);
        check_outs("to_late_byte", 1'b0, 8'h3C, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        check_outs("to_late_byte2", 1'b0, 8'h3C, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 8'hA5, 1'b1);
        drive(1'b1, 8'h00, 1'b1);
        drive(1'b1, 8'h11, 1'b1);
        check_outs("to_next_write", 1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        check_outs("to_next_ack", 1'b0, 8'h11, 1'b1, ACK, 1'b1);
        drive(1'b0, 8'h00, 1'b1);

        // Byte arriving on the last allowed cycle is accepted
        drive(1'b1, 8'hA5, 1'b1);
        drive(1'b1, 8'h00, 1'b1);
        repeat (15) drive(1'b0, 8'h00, 1'b1);
        drive(1'b1, 8'h77, 1'b1);
        check_outs("to_byte_wins", 1'b1, 8'h77, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        check_outs("to_byte_wins_done", 1'b0, 8'h77, 1'b0, 8'h00, 1'b0);

        // Test 4: transmitter stalled; bytes sent during RESP are dropped
        drive(1'b1, 8'hA5, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        drive(1'b1, 8'h42, 1'b0);
        check_outs("bp_write", 1'b1, 8'h42, 1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 20; i++) begin
            drive((i < 3) ? 1'b1 : 1'b0, junk[i % 3], 1'b0);
            check_outs("bp_hold", 1'b0, 8'h42, 1'b1, ACK, 1'b1);
        end
        drive(1'b0, 8'h00, 1'b1);
        check_outs("bp_release", 1'b0, 8'h42, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'h00, 1'b1);
            check_outs("bp_single", 1'b0, 8'h42, 1'b0, 8'h00, 1'b0);
        end

        // Test 5: reset mid-frame discards it
        drive(1'b1, 8'hA5, 1'b1);
        drive(1'b1, 8'h00, 1'b1);
        check_outs("rst_pre", 1'b0, 8'h42, 1'b0, 8'h00, 1'b1);
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b1);
        reset = 1'b0;
        check_outs("rst_mid", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("rst_mid.tx_data", 32'(bus.tx_data), 32'h0);
        drive(1'b1, 8'h22, 1'b1);
        check_outs("rst_data", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b1);
        check_outs("rst_after", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // Test 6: address 8'h80 is readback only with the feature enabled
        drive(1'b1, 8'hA5, 1'b1);
        drive(1'b1, 8'h00, 1'b1);
        drive(1'b1, 8'h5A, 1'b1);
        check_outs("rb_write", 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
`ifdef CONTROL_READBACK_EN
        exp_rb = 8'h5A;
`else
        exp_rb = NACK;
`endif
        drive(1'b1, 8'hA5, 1'b1);
        drive(1'b1, 8'h80, 1'b1);
        drive(1'b1, 8'h00, 1'b1);
        check_outs("rb_resp", 1'b0, 8'h5A, 1'b1, exp_rb, 1'b1);
        drive(1'b0, 8'h00, 1'b1);
        check_outs("rb_done", 1'b0, 8'h5A, 1'b0, 8'h00, 1'b0);

        // Random traffic against the frame-level model
        reset = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        reset = 1'b0;
        model_reset();
        gap = 0;
        for (int n = 0; n < 3000; n++) begin
            if (gap > 0) begin
                gap--;
                rv = 1'b0;
            end else if ($urandom_range(0, 59) == 0) begin
                gap = $urandom_range(12, 20);
                rv  = 1'b0;
            end else begin
                rv = ($urandom_range(0, 2) == 0);
            end
            sel = $urandom_range(0, 99);
            if (sel < 35)      rd = SYNC;
            else if (sel < 60) rd = 8'h00;
            else if (sel < 70) rd = 8'h80;
            else               rd = 8'($urandom);
            tr = ($urandom_range(0, 2) != 0);
            drive(rv, rd, tr);
            model_step(rv, rd, tr);
            check_outs($sformatf("rand%0d", n), m_wpend, m_wreg, m_rpend, m_resp,
                       (m_frame.size() != 0) || m_wpend || m_rpend);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
